// File: rtl/elevador_pkg.sv
// Shared encodings for the elevator dispatcher: accion command codes and FSM states.
package elevador_pkg;

   localparam logic [1:0] ACC_REPOSO  = 2'b00;
   localparam logic [1:0] ACC_LLEGADA = 2'b01;
   localparam logic [1:0] ACC_SUBIR   = 2'b10;
   localparam logic [1:0] ACC_BAJAR   = 2'b11;

   typedef enum logic [2:0] {
      ESPERA,
      SUBIR,
      BAJAR,
      LLEGADA,
      ABRIENDO,
      CERRANDO
   } estado_t;

endpackage

// File: rtl/registro_solicitudes.sv
// Floor-call latch; derives requests above, below and at the current floor.
module registro_solicitudes #(
   parameter int NUM_PISOS = 4,
   parameter int PISO_W    = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NUM_PISOS-1:0] boton_i,
   input  logic [PISO_W-1:0]    piso_i,
   input  logic                 bloqueo_i,
   output logic [NUM_PISOS-1:0] solicitudes_o,
   output logic                 hay_arriba_o,
   output logic                 hay_abajo_o,
   output logic                 aqui_o
);

   logic [NUM_PISOS-1:0] sol_q, sol_d;

   // While the door cycle runs, the current floor's bit is held clear (clear beats a new press).
   always_comb begin
      sol_d = sol_q;
      for (int i = 0; i < NUM_PISOS; i++) begin
         sol_d[i] = sol_q[i] | boton_i[i];
         if (bloqueo_i && (i == int'(piso_i))) sol_d[i] = 1'b0;
      end
   end

   always_comb begin
      hay_arriba_o = 1'b0;
      hay_abajo_o  = 1'b0;
      aqui_o       = 1'b0;
      for (int i = 0; i < NUM_PISOS; i++) begin
         if (i > int'(piso_i)) hay_arriba_o = hay_arriba_o | sol_q[i];
         if (i < int'(piso_i)) hay_abajo_o  = hay_abajo_o | sol_q[i];
         if (i == int'(piso_i)) aqui_o = sol_q[i];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) sol_q <= '0;
      else         sol_q <= sol_d;
   end

   assign solicitudes_o = sol_q;

endmodule

// File: rtl/despachador_elevador.sv
// SCAN request dispatcher: tracks the cabin floor and issues the 2-bit accion command.
module despachador_elevador
   import elevador_pkg::*;
#(
   parameter int NUM_PISOS = 4,
   parameter int PISO_W    = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_PISOS-1:0] boton_piso,
   input  logic                 paso_piso,
   input  logic                 puerta_cerrada,
   output logic [1:0]           accion,
   output logic [PISO_W-1:0]    piso_actual,
   output logic [NUM_PISOS-1:0] solicitudes,
   output logic                 direccion_arriba
);

   estado_t             estado_q;
   logic [PISO_W-1:0]   piso_q;
   logic                dir_q;
   logic [1:0]          accion_q;
   logic                hay_arriba, hay_abajo, aqui, bloqueo;
   logic                sig_arriba, sig_abajo;

   assign bloqueo = (estado_q == LLEGADA) || (estado_q == ABRIENDO) || (estado_q == CERRANDO);

   registro_solicitudes #(
      .NUM_PISOS (NUM_PISOS),
      .PISO_W    (PISO_W)
   ) u_registro (
      .clk_i         (clk),
      .rst_ni        (reset),
      .boton_i       (boton_piso),
      .piso_i        (piso_q),
      .bloqueo_i     (bloqueo),
      .solicitudes_o (solicitudes),
      .hay_arriba_o  (hay_arriba),
      .hay_abajo_o   (hay_abajo),
      .aqui_o        (aqui)
   );

   // Request bit of the floor the cabin is about to enter in either direction.
   always_comb begin
      sig_arriba = 1'b0;
      sig_abajo  = 1'b0;
      for (int i = 0; i < NUM_PISOS; i++) begin
         if (i == int'(piso_q) + 1) sig_arriba = solicitudes[i];
         if (i == int'(piso_q) - 1) sig_abajo  = solicitudes[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         estado_q <= ESPERA;
         piso_q   <= '0;
         dir_q    <= 1'b1;
         accion_q <= ACC_REPOSO;
      end else begin
         case (estado_q)
            ESPERA: begin
               if (aqui) begin
                  estado_q <= LLEGADA;
                  accion_q <= ACC_LLEGADA;
               end else if (hay_arriba && (dir_q || !hay_abajo)) begin
                  estado_q <= SUBIR;
                  dir_q    <= 1'b1;
                  accion_q <= ACC_SUBIR;
               end else if (hay_abajo) begin
                  estado_q <= BAJAR;
                  dir_q    <= 1'b0;
                  accion_q <= ACC_BAJAR;
               end
            end
            SUBIR: begin
               if (paso_piso && (piso_q != PISO_W'(NUM_PISOS - 1))) begin
                  piso_q <= piso_q + PISO_W'(1);
                  if (sig_arriba) begin
                     estado_q <= LLEGADA;
                     accion_q <= ACC_LLEGADA;
                  end
               end
            end
            BAJAR: begin
               if (paso_piso && (piso_q != '0)) begin
                  piso_q <= piso_q - PISO_W'(1);
                  if (sig_abajo) begin
                     estado_q <= LLEGADA;
                     accion_q <= ACC_LLEGADA;
                  end
               end
            end
            LLEGADA: begin
               estado_q <= ABRIENDO;
               accion_q <= ACC_REPOSO;
            end
            ABRIENDO: begin
               if (!puerta_cerrada) estado_q <= CERRANDO;
            end
            CERRANDO: begin
               if (puerta_cerrada) estado_q <= ESPERA;
            end
            default: begin
               estado_q <= ESPERA;
               accion_q <= ACC_REPOSO;
            end
         endcase
      end
   end

   assign accion           = accion_q;
   assign piso_actual      = piso_q;
   assign direccion_arriba = dir_q;

endmodule
